inst_dispatch: RTL and testbench

Parametrised instruction queue and dispatcher for the NPU core. It accepts instruction words from the fetch unit over a valid/ready handshake and buffers them in a FIFO. It decodes the head entry, latches per-class payload registers and issues start strobes to the DMA engine and the compute core. It also enforces DMA blocking and no-block ordering, executes JUMP and STOP, and flags illegal opcodes.

---
 rtl/inst_dispatch.sv | 191 +++++++++++++++++++
 tb/tb_inst_dispatch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_dispatch.sv
// Instruction FIFO plus dispatcher: decodes the head entry, latches per-class payloads and
// launches DMA/compute work while tracking outstanding DMAs, jumps, stops and illegal opcodes.
module inst_dispatch #(
  parameter int INST_W  = 128,
  parameter int OPC_W   = 5,
  parameter int PC_W    = 12,
  parameter int DEPTH   = 4,
  parameter int MAX_DMA = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            clr,
  input  logic                            i_start,
  input  logic [INST_W-1:0]               i_inst,
  input  logic                            i_inst_valid,
  output logic                            o_inst_ready,
  output logic [INST_W-OPC_W-1:0]         o_dma_pl,
  output logic [INST_W-OPC_W-1:0]         o_iob_pl,
  output logic [INST_W-OPC_W-1:0]         o_wb_pl,
  output logic [INST_W-OPC_W-1:0]         o_n2iob_pl,
  output logic [INST_W-OPC_W-1:0]         o_sm_pl,
  output logic [4:0]                      o_cfg_upd,
  output logic                            o_dma_start,
  input  logic                            i_dma_done,
  output logic [$clog2(MAX_DMA+1)-1:0]    o_dma_outstanding,
  output logic                            o_core_start,
  output logic                            o_core_op,
  input  logic                            i_core_done,
  output logic                            o_jump_valid,
  output logic [PC_W-1:0]                 o_jump_pc,
  output logic                            o_stop,
  output logic                            o_err_inst,
  output logic [OPC_W-1:0]                o_err_opcode
);
  localparam int PL_W  = INST_W - OPC_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(MAX_DMA + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DMA);

  localparam logic [OPC_W-1:0] OP_DMA     = OPC_W'(5'b10010);
  localparam logic [OPC_W-1:0] OP_IOB2N   = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OP_WB2N    = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OP_N2IOB   = OPC_W'(5'b01101);
  localparam logic [OPC_W-1:0] OP_SOFTMAX = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_STOP    = OPC_W'(5'b11111);
  localparam logic [OPC_W-1:0] OP_JUMP    = OPC_W'(5'b11100);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_WAIT_DMA  = 3'd2;
  localparam logic [2:0] S_WAIT_CORE = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr, r_wptr_d;
  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_inst_ready, r_dma_start, r_core_start, r_core_op, r_jump_valid, r_stop;
  logic              r_err_inst;
  logic [OPC_W-1:0]  r_err_opcode;
  logic [4:0]        r_cfg_upd;
  logic [PL_W-1:0]   r_dma_pl, r_iob_pl, r_wb_pl, r_n2iob_pl, r_sm_pl;
  logic [PC_W-1:0]   r_jump_pc;

  logic [INST_W-1:0] w_head;
  logic [OPC_W-1:0]  w_op;
  logic [PL_W-1:0]   w_pl;
  logic              w_avail, w_push, w_pop, w_flush, w_dma_go, w_core_go, w_core_op, w_err, w_dec;
  logic [4:0]        w_cfg;
  logic [2:0]        w_state_n;
  logic [PTR_W-1:0]  w_wptr_n, w_rptr_n, w_used_n;
  logic [CNT_W-1:0]  w_cnt_n;

  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_op    = w_head[INST_W-1 -: OPC_W];
  assign w_pl    = w_head[PL_W-1:0];
  // An entry becomes eligible for dispatch one edge after it is written.
  assign w_avail = (r_wptr_d != r_rptr);
  assign w_push  = i_inst_valid & r_inst_ready;

  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_flush   = 1'b0;
    w_cfg     = '0;
    w_dma_go  = 1'b0;
    w_core_go = 1'b0;
    w_core_op = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: if (i_start) w_state_n = S_RUN;
      S_RUN: begin
        if (w_avail && !(w_head[37] && r_cnt != '0)) begin
          case (w_op)
            OP_IOB2N: begin w_cfg[1] = 1'b1; w_pop = 1'b1; end
            OP_WB2N:  begin w_cfg[2] = 1'b1; w_pop = 1'b1; end
            OP_DMA: begin
              if (r_cnt != MAX_CNT) begin
                w_cfg[0] = 1'b1;
                w_dma_go = 1'b1;
                w_pop    = 1'b1;
                if (!w_head[20]) w_state_n = S_WAIT_DMA;
              end
            end
            OP_N2IOB: begin
              w_cfg[3] = 1'b1; w_core_go = 1'b1; w_pop = 1'b1; w_state_n = S_WAIT_CORE;
            end
            OP_SOFTMAX: begin
              w_cfg[4] = 1'b1; w_core_go = 1'b1; w_core_op = 1'b1; w_pop = 1'b1;
              w_state_n = S_WAIT_CORE;
            end
            OP_JUMP: w_flush = 1'b1;
            OP_STOP: begin w_pop = 1'b1; w_state_n = S_HALT; end
            default: begin w_pop = 1'b1; w_err = 1'b1; end
          endcase
        end
      end
      S_WAIT_DMA:  if (r_cnt == '0 || (r_cnt == CNT_W'(1) && i_dma_done)) w_state_n = S_RUN;
      S_WAIT_CORE: if (i_core_done) w_state_n = S_RUN;
      default:     w_state_n = S_IDLE;
    endcase
  end

  assign w_dec    = i_dma_done && (r_cnt != '0);
  assign w_cnt_n  = r_cnt + CNT_W'(w_dma_go) - CNT_W'(w_dec);
  assign w_wptr_n = r_wptr + PTR_W'(w_push);
  // A jump discards everything, including a word accepted in the same cycle.
  assign w_rptr_n = w_flush ? w_wptr_n : r_rptr + PTR_W'(w_pop);
  assign w_used_n = w_wptr_n - w_rptr_n;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_inst;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE; r_wptr <= '0; r_rptr <= '0; r_wptr_d <= '0; r_cnt <= '0;
      r_inst_ready <= 1'b0; r_cfg_upd <= '0; r_dma_start <= 1'b0; r_core_start <= 1'b0;
      r_core_op <= 1'b0; r_jump_valid <= 1'b0; r_jump_pc <= '0; r_stop <= 1'b0;
      r_err_inst <= 1'b0; r_err_opcode <= '0;
      r_dma_pl <= '0; r_iob_pl <= '0; r_wb_pl <= '0; r_n2iob_pl <= '0; r_sm_pl <= '0;
    end else if (clr) begin
      r_state <= S_IDLE; r_wptr <= '0; r_rptr <= '0; r_wptr_d <= '0; r_cnt <= '0;
      r_inst_ready <= 1'b0; r_cfg_upd <= '0; r_dma_start <= 1'b0; r_core_start <= 1'b0;
      r_core_op <= 1'b0; r_jump_valid <= 1'b0; r_jump_pc <= '0; r_stop <= 1'b0;
      r_err_inst <= 1'b0; r_err_opcode <= '0;
      r_dma_pl <= '0; r_iob_pl <= '0; r_wb_pl <= '0; r_n2iob_pl <= '0; r_sm_pl <= '0;
    end else begin
      r_state      <= w_state_n;
      r_wptr       <= w_wptr_n;
      r_rptr       <= w_rptr_n;
      r_wptr_d     <= w_flush ? w_wptr_n : r_wptr;
      r_cnt        <= w_cnt_n;
      r_inst_ready <= (w_used_n != PTR_W'(DEPTH)) && !w_flush;
      r_cfg_upd    <= w_cfg;
      r_dma_start  <= w_dma_go;
      r_core_start <= w_core_go;
      r_jump_valid <= w_flush;
      r_stop       <= (w_state_n == S_HALT);
      if (w_core_go) r_core_op <= w_core_op;
      if (w_flush)   r_jump_pc <= w_head[INST_W-OPC_W-1 -: PC_W];
      if (w_cfg[0])  r_dma_pl   <= w_pl;
      if (w_cfg[1])  r_iob_pl   <= w_pl;
      if (w_cfg[2])  r_wb_pl    <= w_pl;
      if (w_cfg[3])  r_n2iob_pl <= w_pl;
      if (w_cfg[4])  r_sm_pl    <= w_pl;
      if (w_err && !r_err_inst) begin
        r_err_inst   <= 1'b1;
        r_err_opcode <= w_op;
      end
    end
  end

  assign o_inst_ready      = r_inst_ready;
  assign o_dma_pl          = r_dma_pl;
  assign o_iob_pl          = r_iob_pl;
  assign o_wb_pl           = r_wb_pl;
  assign o_n2iob_pl        = r_n2iob_pl;
  assign o_sm_pl           = r_sm_pl;
  assign o_cfg_upd         = r_cfg_upd;
  assign o_dma_start       = r_dma_start;
  assign o_dma_outstanding = r_cnt;
  assign o_core_start      = r_core_start;
  assign o_core_op         = r_core_op;
  assign o_jump_valid      = r_jump_valid;
  assign o_jump_pc         = r_jump_pc;
  assign o_stop            = r_stop;
  assign o_err_inst        = r_err_inst;
  assign o_err_opcode      = r_err_opcode;
endmodule

// File: tb/tb_inst_dispatch.sv
// Directed bench for inst_dispatch: cycle tables of {inputs, expected outputs} plus
// hand-written sequences for jump flush, illegal opcodes/stop and clear.
module tb_inst_dispatch;
  localparam int IW = 128;

  localparam logic [4:0] OP_DMA     = 5'b10010;
  localparam logic [4:0] OP_IOB2N   = 5'b01010;
  localparam logic [4:0] OP_WB2N    = 5'b01011;
  localparam logic [4:0] OP_N2IOB   = 5'b01101;
  localparam logic [4:0] OP_SOFTMAX = 5'b00110;
  localparam logic [4:0] OP_STOP    = 5'b11111;
  localparam logic [4:0] OP_JUMP    = 5'b11100;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          clr = 1'b0, i_start = 1'b0, i_inst_valid = 1'b0;
  logic          i_dma_done = 1'b0, i_core_done = 1'b0;
  logic [IW-1:0] i_inst = '0;
  logic          o_inst_ready, o_dma_start, o_core_start, o_core_op, o_jump_valid, o_stop, o_err_inst;
  logic [122:0]  o_dma_pl, o_iob_pl, o_wb_pl, o_n2iob_pl, o_sm_pl;
  logic [4:0]    o_cfg_upd, o_err_opcode;
  logic [1:0]    o_dma_outstanding;
  logic [11:0]   o_jump_pc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  inst_dispatch #(.INST_W(128), .OPC_W(5), .PC_W(12), .DEPTH(4), .MAX_DMA(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clr(clr), .i_start(i_start),
    .i_inst(i_inst), .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .o_dma_pl(o_dma_pl), .o_iob_pl(o_iob_pl), .o_wb_pl(o_wb_pl),
    .o_n2iob_pl(o_n2iob_pl), .o_sm_pl(o_sm_pl), .o_cfg_upd(o_cfg_upd),
    .o_dma_start(o_dma_start), .i_dma_done(i_dma_done),
    .o_dma_outstanding(o_dma_outstanding), .o_core_start(o_core_start),
    .o_core_op(o_core_op), .i_core_done(i_core_done), .o_jump_valid(o_jump_valid),
    .o_jump_pc(o_jump_pc), .o_stop(o_stop), .o_err_inst(o_err_inst),
    .o_err_opcode(o_err_opcode)
  );

  typedef struct {
    logic          c, s, vl;
    logic [IW-1:0] in;
    logic          dd, cd;
    logic [12:0]   exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [IW-1:0] mk(input logic [4:0] op, input int wt, input int nb,
                                       input logic [15:0] tag);
    logic [IW-1:0] x;
    x = '0;
    x[IW-1 -: 5] = op;
    x[37]        = 1'(wt);
    x[20]        = 1'(nb);
    x[15:0]      = tag;
    x[60 +: 16]  = ~tag;
    return x;
  endfunction

  function automatic logic [IW-1:0] mkj(input logic [11:0] pc);
    logic [IW-1:0] x;
    x = mk(OP_JUMP, 0, 0, 16'h0);
    x[122 -: 12] = pc;
    return x;
  endfunction

  // Observed bundle: {ready, cfg_upd[4:0], dma_start, core_start, core_op, outstanding[1:0], stop, jump_valid}
  function automatic logic [12:0] ex(input int rdy, input int cfg, input int ds, input int cs,
                                     input int cop, input int cnt, input int stp, input int jv);
    return {1'(rdy), 5'(cfg), 1'(ds), 1'(cs), 1'(cop), 2'(cnt), 1'(stp), 1'(jv)};
  endfunction

  function automatic logic [12:0] obs();
    return {o_inst_ready, o_cfg_upd, o_dma_start, o_core_start, o_core_op,
            o_dma_outstanding, o_stop, o_jump_valid};
  endfunction

  function automatic vec_t row(input int c, input int s, input int vl, input logic [IW-1:0] in,
                               input int dd, input int cd, input logic [12:0] e);
    vec_t r;
    r.c = 1'(c); r.s = 1'(s); r.vl = 1'(vl); r.in = in;
    r.dd = 1'(dd); r.cd = 1'(cd); r.exp = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic step(input int c, input int s, input int vl, input logic [IW-1:0] in,
                      input int dd, input int cd);
    clr = 1'(c); i_start = 1'(s); i_inst_valid = 1'(vl); i_inst = in;
    i_dma_done = 1'(dd); i_core_done = 1'(cd);
    @(posedge i_clk);
    #1;
    clr = 1'b0; i_start = 1'b0; i_inst_valid = 1'b0; i_dma_done = 1'b0; i_core_done = 1'b0;
  endtask

  task automatic run_tbl(input string grp);
    foreach (tv[k]) begin
      step(tv[k].c, tv[k].s, tv[k].vl, tv[k].in, tv[k].dd, tv[k].cd);
      chk($sformatf("%s row %0d", grp, k), 128'(obs()), 128'(tv[k].exp));
    end
    tv.delete();
  endtask

  logic [IW-1:0] a_iob1, a_wb, a_n2, a_iob2, d1, d2, d3, d4;
  logic [IW-1:0] c_dma, c_iobw, c_dmab, c_iob, f_sm, f_iob, f_wb, stop_i;
  logic [12:0]   z;

  initial begin
    a_iob1 = mk(OP_IOB2N, 0, 0, 16'h1111);  a_wb   = mk(OP_WB2N, 0, 0, 16'h2222);
    a_n2   = mk(OP_N2IOB, 0, 0, 16'h3333);  a_iob2 = mk(OP_IOB2N, 0, 0, 16'h4444);
    d1 = mk(OP_DMA, 0, 1, 16'hD001); d2 = mk(OP_DMA, 0, 1, 16'hD002);
    d3 = mk(OP_DMA, 0, 1, 16'hD003); d4 = mk(OP_DMA, 0, 1, 16'hD004);
    c_dma  = mk(OP_DMA, 0, 1, 16'hC001);   c_iobw = mk(OP_IOB2N, 1, 0, 16'hC002);
    c_dmab = mk(OP_DMA, 0, 0, 16'hC003);   c_iob  = mk(OP_IOB2N, 0, 0, 16'hC004);
    f_sm   = mk(OP_SOFTMAX, 0, 0, 16'hF001); f_iob = mk(OP_IOB2N, 0, 0, 16'hF002);
    f_wb   = mk(OP_WB2N, 0, 0, 16'hF003);  stop_i = mk(OP_STOP, 0, 0, 16'h0);
    z = '0;

    repeat (2) @(posedge i_clk);
    #1;
    chk("reset bundle", 128'(obs()), 128'(z));
    chk("reset err", 128'({o_err_inst, o_err_opcode, o_jump_pc}), 128'(0));
    i_rst_n = 1'b1;
    step(0, 0, 0, '0, 0, 0);
    chk("ready after reset", 128'(obs()), 128'(ex(1, 0, 0, 0, 0, 0, 0, 0)));

    // Config instructions at one per cycle, then N2IOB holds the next head until core done.
    tv.push_back(row(0, 1, 1, a_iob1, 0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, a_wb,   0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, a_n2,   0, 0, ex(1, 5'h02, 0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, a_iob2, 0, 0, ex(1, 5'h04, 0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 5'h08, 0, 1, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 1, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 5'h02, 0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    run_tbl("cfg");
    chk("iob payload", 128'(o_iob_pl),   128'(a_iob2[122:0]));
    chk("wb payload",  128'(o_wb_pl),    128'(a_wb[122:0]));
    chk("n2 payload",  128'(o_n2iob_pl), 128'(a_n2[122:0]));

    // Four NOBLOCK DMAs: the fourth waits for a done pulse at the outstanding limit.
    tv.push_back(row(0, 0, 1, d1, 0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, d2, 0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, d3, 0, 0, ex(1, 5'h01, 1, 0, 0, 1, 0, 0)));
    tv.push_back(row(0, 0, 1, d4, 0, 0, ex(1, 5'h01, 1, 0, 0, 2, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 0, 0, ex(1, 5'h01, 1, 0, 0, 3, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 0, 0, ex(1, 0,     0, 0, 0, 3, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 0, 0, ex(1, 0,     0, 0, 0, 3, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 1, 0, ex(1, 0,     0, 0, 0, 2, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 0, 0, ex(1, 5'h01, 1, 0, 0, 3, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 1, 0, ex(1, 0,     0, 0, 0, 2, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 1, 0, ex(1, 0,     0, 0, 0, 1, 0, 0)));
    tv.push_back(row(0, 0, 0, '0, 1, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    run_tbl("dma limit");
    chk("dma payload", 128'(o_dma_pl), 128'(d4[122:0]));

    // WAIT bit behind a NOBLOCK DMA, then a blocking DMA holding WAIT_DMA.
    tv.push_back(row(0, 0, 1, c_dma,  0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, c_iobw, 0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 5'h01, 1, 0, 0, 1, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 0,     0, 0, 0, 1, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     1, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 5'h02, 0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, c_dmab, 0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 1, c_iob,  0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 5'h01, 1, 0, 0, 1, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 0,     0, 0, 0, 1, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 0,     0, 0, 0, 1, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     1, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 5'h02, 0, 0, 0, 0, 0, 0)));
    tv.push_back(row(0, 0, 0, '0,     0, 0, ex(1, 0,     0, 0, 0, 0, 0, 0)));
    run_tbl("dma wait");

    // Full FIFO with JUMP at head: flush, one-cycle ready drop, queued STOP discarded.
    step(1, 0, 0, '0, 0, 0);
    chk("clr bundle", 128'(obs()), 128'(z));
    step(0, 0, 0, '0, 0, 0);
    chk("ready after clr", 128'(obs()), 128'(ex(1, 0, 0, 0, 0, 0, 0, 0)));
    step(0, 0, 1, mkj(12'h123), 0, 0);
    step(0, 0, 1, stop_i, 0, 0);
    step(0, 0, 1, a_iob1, 0, 0);
    step(0, 0, 1, a_wb, 0, 0);
    chk("fifo full", 128'(obs()), 128'(ex(0, 0, 0, 0, 0, 0, 0, 0)));
    step(0, 1, 0, '0, 0, 0);
    chk("start while full", 128'(obs()), 128'(ex(0, 0, 0, 0, 0, 0, 0, 0)));
    step(0, 0, 0, '0, 0, 0);
    chk("jump pulse", 128'(obs()), 128'(ex(0, 0, 0, 0, 0, 0, 0, 1)));
    chk("jump pc", 128'(o_jump_pc), 128'(12'h123));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0, 0, 0);
      chk($sformatf("after flush %0d", i), 128'(obs()), 128'(ex(1, 0, 0, 0, 0, 0, 0, 0)));
    end

    // Two illegal opcodes then STOP: only the first opcode is captured.
    step(0, 0, 1, mk(5'b00001, 0, 0, 16'hE001), 0, 0);
    step(0, 0, 1, mk(5'b00010, 0, 0, 16'hE002), 0, 0);
    step(0, 0, 1, stop_i, 0, 0);
    chk("err first", 128'({o_err_inst, o_err_opcode}), 128'({1'b1, 5'b00001}));
    step(0, 0, 0, '0, 0, 0);
    chk("err sticky opcode", 128'({o_err_inst, o_err_opcode}), 128'({1'b1, 5'b00001}));
    step(0, 0, 0, '0, 0, 0);
    chk("halt", 128'(obs()), 128'(ex(1, 0, 0, 0, 0, 0, 1, 0)));
    step(1, 0, 0, '0, 0, 0);
    chk("clr err", 128'({o_err_inst, o_err_opcode}), 128'(0));
    chk("clr stop", 128'(obs()), 128'(z));

    // Clear while waiting on the core with two entries still queued.
    step(0, 0, 0, '0, 0, 0);
    step(0, 1, 1, f_sm, 0, 0);
    step(0, 0, 1, f_iob, 0, 0);
    step(0, 0, 1, f_wb, 0, 0);
    chk("softmax launch", 128'(obs()), 128'(ex(1, 5'h10, 0, 1, 1, 0, 0, 0)));
    chk("sm payload", 128'(o_sm_pl), 128'(f_sm[122:0]));
    step(1, 0, 0, '0, 0, 0);
    chk("clr in wait_core", 128'(obs()), 128'(z));
    chk("clr payloads", 128'({o_sm_pl, o_iob_pl}), 128'(0));
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 1);
    chk("late core done", 128'(obs()), 128'(ex(1, 0, 0, 0, 0, 0, 0, 0)));
    step(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0, 0, 0);
      chk($sformatf("empty after clr %0d", i), 128'(obs()), 128'(ex(1, 0, 0, 0, 0, 0, 0, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
